// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between an
// instruction-fetch requester (I) and a data requester (D).
// Handshake: a requester raises *_req with stable address/data and keeps it
// until its one-cycle *_ready pulse; the memory side sees mem_req held high
// until mem_ack (read data valid in the ack cycle) or until the timeout.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int              SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [7:0]      TCNT_LAST  = 8'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic              owner_d_q, owner_d_d;   // 1 = D owns the transaction
    logic              err_pend_q, err_pend_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_i;
    logic [DATA_W-1:0] resp_data;

    // Next-state, arbitration and transaction capture
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tcnt_d      = tcnt_q;
        owner_d_d   = owner_d_q;
        err_pend_d  = err_pend_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        // D normally wins; I is forced through once D has had its full streak.
        grant_i     = i_req && (!d_req || (streak_q == STREAK_MAX));
        // Writes return zero; a timeout also returns zero.
        resp_data   = (mem_ack && !mem_we_q) ? mem_rdata : '0;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    state_d    = S_BUSY;
                    tcnt_d     = '0;
                    err_pend_d = 1'b0;
                    owner_d_d  = !grant_i;
                    if (grant_i) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end else begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (!i_req) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end
                end
            end
            S_BUSY: begin
                tcnt_d = tcnt_q + 8'd1;
                // Ack on the threshold cycle beats the timeout.
                if (mem_ack || (tcnt_q == TCNT_LAST)) begin
                    state_d    = S_RESP;
                    err_pend_d = !mem_ack;
                    if (owner_d_q) begin
                        d_rdata_d = resp_data;
                    end else begin
                        i_rdata_d = resp_data;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            tcnt_q      <= '0;
            owner_d_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tcnt_q      <= tcnt_d;
            owner_d_q   <= owner_d_d;
            err_pend_q  <= err_pend_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Outputs decode straight from registered state, so reset drops them at once
    assign mem_req   = (state_q == S_BUSY);
    assign i_ready   = (state_q == S_RESP) && !owner_d_q;
    assign d_ready   = (state_q == S_RESP) && owner_d_q;
    assign err       = (state_q == S_RESP) && err_pend_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, checked
// by a scoreboard of per-port expected responses and a grant-order model.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TOUT = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          i_req, i_ready, d_req, d_we, d_ready;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic          mem_req, mem_we, mem_ack, err;
    logic [1:0]    dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .dbg_state(dbg_state)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model (DUT side) and reference store ----------------
    logic [DW-1:0] mem_arr [int unsigned];
    logic [DW-1:0] ref_mem [int unsigned];
    bit no_ack    = 0;
    bit rand_mode = 0;
    int ack_lat   = 0;
    int busy_cnt  = 0;
    int cur_lat   = 0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Memory responder: acks after cur_lat extra BUSY cycles, sprays junk acks when idle
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (busy_cnt == 0) cur_lat = rand_mode ? $urandom_range(0, 4) : ack_lat;
                busy_cnt++;
                if (!no_ack && busy_cnt == cur_lat + 1) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_arr[mem_addr] = mem_wdata;
                        mem_rdata = $urandom;
                    end else begin
                        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : dflt(mem_addr);
                    end
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                busy_cnt  = 0;
                mem_ack   = rand_mode && ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [DW:0] i_exp_q[$];
    logic [DW:0] d_exp_q[$];
    logic        grant_log[$];   // 1 = I grant
    logic [DW:0] exp_v;
    logic        pi_prev = 0, pd_prev = 0, mreq_prev = 0;
    logic        exp_i, act_i;
    logic [DW-1:0] irdata_prev = '0, drdata_prev = '0;
    int streak_m = 0;
    int rise_cyc = 0, rdy_cyc = 0, busy_run = 0, busy_len = 0;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_we;

    always @(negedge clk) begin
        if (!reset) begin
            streak_m = 0;
            busy_run = 0;
        end else begin
            if (mem_req && !mreq_prev) begin
                exp_i = pi_prev && (!pd_prev || streak_m == MAXS);
                act_i = (mem_addr < 32'h200);
                check("grant_winner", act_i, exp_i);
                grant_log.push_back(act_i);
                if (act_i) streak_m = 0;
                else if (pi_prev) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
                else streak_m = 0;
                rise_cyc = cyc;
                g_addr = mem_addr;
                g_we = mem_we;
                g_wdata = mem_wdata;
            end
            if (mem_req) busy_run++;
            else if (mreq_prev) begin
                busy_len = busy_run;
                busy_run = 0;
            end
            check("both_ready", i_ready && d_ready, 0);
            check("err_only_with_ready", err && !(i_ready || d_ready), 0);
            if (i_ready) begin
                rdy_cyc = cyc;
                check("i_ready_expected", i_exp_q.size() != 0, 1);
                if (i_exp_q.size() != 0) begin
                    exp_v = i_exp_q.pop_front();
                    check("i_resp", {err, i_rdata}, exp_v);
                end
            end else begin
                check("i_rdata_hold", i_rdata, irdata_prev);
            end
            if (d_ready) begin
                rdy_cyc = cyc;
                check("d_ready_expected", d_exp_q.size() != 0, 1);
                if (d_exp_q.size() != 0) begin
                    exp_v = d_exp_q.pop_front();
                    check("d_resp", {err, d_rdata}, exp_v);
                end
            end else begin
                check("d_rdata_hold", d_rdata, drdata_prev);
            end
        end
        pi_prev = i_req;
        pd_prev = d_req;
        mreq_prev = mem_req;
        irdata_prev = i_rdata;
        drdata_prev = d_rdata;
    end

    // ---------------- driver tasks ----------------
    task automatic i_read(input logic [AW-1:0] addr);
        bit got = 0;
        i_addr = addr;
        i_req  = 1'b1;
        i_exp_q.push_back(no_ack ? {1'b1, 32'h0} : {1'b0, ref_rd(addr)});
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (i_ready) begin
                got = 1;
                break;
            end
        end
        check("i_wait_ready", got, 1);
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic d_xfer(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bit got = 0;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_req   = 1'b1;
        if (no_ack) d_exp_q.push_back({1'b1, 32'h0});
        else if (we) begin
            d_exp_q.push_back({1'b0, 32'h0});
            ref_mem[addr] = wdata;
        end else d_exp_q.push_back({1'b0, ref_rd(addr)});
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (d_ready) begin
                got = 1;
                break;
            end
        end
        check("d_wait_ready", got, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] pat;
    bit got_busy;

    initial begin
        reset = 1'b0;
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        idle(3);
        check("rst_state", dbg_state, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_readys_err", {i_ready, d_ready, err}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        reset = 1'b1;
        idle(2);

        // I read, ack two cycles after mem_req rises
        mem_arr[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        ack_lat = 2;
        i_read(32'h100);
        check("t1_mem_addr", g_addr, 32'h100);
        check("t1_mem_we", g_we, 0);
        check("t1_latency", rdy_cyc - rise_cyc, 3);
        check("t1_i_rdata", i_rdata, 32'hDEADBEEF);

        // D write, ack in first BUSY cycle
        ack_lat = 0;
        d_xfer(1'b1, 32'h200, 32'h12345678);
        check("t2_mem_we", g_we, 1);
        check("t2_mem_wdata", g_wdata, 32'h12345678);
        check("t2_latency", rdy_cyc - rise_cyc, 1);
        check("t2_d_rdata", d_rdata, 0);
        check("t2_mem_written", mem_arr[32'h200], 32'h12345678);

        // Simultaneous I and D
        grant_log.delete();
        ack_lat = 1;
        fork
            i_read(32'h104);
            d_xfer(1'b0, 32'h200, '0);
        join
        check("t3_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) check("t3_order", {grant_log[0], grant_log[1]}, 2'b01);

        // D streak while I waits
        grant_log.delete();
        ack_lat = 0;
        fork
            i_read(32'h108);
            for (int k = 0; k < 6; k++) d_xfer(1'b1, 32'h210 + 4 * k, $urandom);
        join
        pat = 7'b0010000;
        check("t4_grants", grant_log.size(), 7);
        for (int k = 0; k < 7 && k < grant_log.size(); k++) check("t4_order", grant_log[k], pat[k]);

        // Timeout, then a normal request
        no_ack = 1;
        d_xfer(1'b0, 32'h208, '0);
        check("t5_busy_len", busy_len, TOUT);
        check("t5_latency", rdy_cyc - rise_cyc, TOUT);
        no_ack = 0;
        ack_lat = 1;
        d_xfer(1'b0, 32'h210, '0);

        // Ack exactly on the timeout threshold
        ack_lat = TOUT - 1;
        d_xfer(1'b0, 32'h200, '0);
        check("t6_latency", rdy_cyc - rise_cyc, TOUT);

        // Reset mid-BUSY
        no_ack = 1;
        d_we = 1'b0; d_addr = 32'h20C; d_req = 1'b1;
        got_busy = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                got_busy = 1;
                break;
            end
        end
        check("t7_busy_seen", got_busy, 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("t7_async_mem_req", mem_req, 0);
        check("t7_async_state", dbg_state, 0);
        check("t7_async_outs", {d_ready, err, d_rdata}, 0);
        d_req = 1'b0;
        idle(2);
        reset = 1'b1;
        no_ack = 0;
        idle(3);
        check("t7_no_ready", d_exp_q.size(), 0);
        ack_lat = 0;
        i_read(32'h100);

        // Randomized traffic
        rand_mode = 1;
        fork
            for (int k = 0; k < 40; k++) begin
                idle($urandom_range(0, 3));
                i_read({$urandom_range(0, 127), 2'b00});
            end
            for (int k = 0; k < 40; k++) begin
                idle($urandom_range(0, 3));
                d_xfer($urandom_range(0, 1), 32'h200 + {$urandom_range(0, 127), 2'b00}, $urandom);
            end
        join
        rand_mode = 0;
        idle(5);
        check("end_i_queue_empty", i_exp_q.size(), 0);
        check("end_d_queue_empty", d_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, variable-latency memory between the pipeline's instruction-fetch port and data-memory port. It arbitrates between requesters and sequences each transaction through a request/acknowledge handshake. It returns read data and a one-cycle ready pulse to the winning requester, and reports ack timeouts. It sits between `riscv` (its `mem_i_*` / `mem_d_*` ports, wrapped with req/ready) and the unified memory.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_D_STREAK`, default 4: maximum number of consecutive D grants while I is pending; must be ≥1.
- `TIMEOUT`, default 255: number of cycles in BUSY without `mem_ack` before the transaction is aborted; must be ≥1 and <256.
- `clk  in  1` — single clock; all state changes on the rising edge.
- `reset  in  1` — asynchronous, active-low (asserted when 0).
- `i_req  in  1` — instruction read request.
- `i_addr  in  ADDR_W` — instruction address.
- `i_ready  out  1` — one-cycle pulse; `i_rdata` is valid in that cycle.
- `i_rdata  out  DATA_W` — instruction read data.
- `d_req  in  1` — data request.
- `d_we  in  1` — 1 = write, 0 = read.
- `d_addr  in  ADDR_W` — data address.
- `d_wdata  in  DATA_W` — data write value.
- `d_ready  out  1` — one-cycle completion pulse.
- `d_rdata  out  DATA_W` — data read data (0 for writes).
- `mem_req  out  1` — request to memory; held until ack.
- `mem_we  out  1` — write enable to memory.
- `mem_addr  out  ADDR_W` — memory address.
- `mem_wdata  out  DATA_W` — memory write data.
- `mem_ack  in  1` — memory completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata  in  DATA_W` — memory read data.
- `err  out  1` — one-cycle pulse, coincident with the `*_ready` of a timed-out transaction.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any request is present: choose a winner, register `mem_we`, `mem_addr` and `mem_wdata` from that requester, record the owner (I/D), go to BUSY.
  - Otherwise stay in IDLE.
- **Arbitration**
  - D has priority over I.
  - Exception: I wins if `i_req`=1 and `streak` = `MAX_D_STREAK`.
- **streak counter**
  - Increments on each D grant made while `i_req`=1; saturates at `MAX_D_STREAK`.
  - Clears on any I grant.
  - Clears on a D grant made while `i_req`=0.
- **BUSY**
  - `mem_req`=1; address and data held stable.
  - `tcnt` increments each BUSY cycle.
  - On `mem_ack`: capture `mem_rdata` into the owner's rdata register (write → 0), go to RESP.
  - If `tcnt` reaches `TIMEOUT` without ack: capture rdata = 0, set `err_pend`, go to RESP.
  - `tcnt` clears on entry to BUSY.
- **RESP**
  - Owner's `*_ready`=1 for exactly one cycle; `err`=`err_pend`.
  - `mem_req`=0; go to IDLE.
  - No new grant is made in RESP.
- **Requester contract**
  - A requester holds req, addr, wdata and we stable from assertion until its ready pulse.
  - It may deassert req or present a new request in the cycle after ready.
  - The arbiter never samples a requester's signals except at grant.
- The non-owner's ready is never asserted. `*_rdata` holds its last value outside the ready pulse.
- A `mem_ack` arriving in IDLE or RESP is ignored.

## Timing
- **Reset:**
  - state = IDLE, `streak` = 0, `tcnt` = 0.
  - `mem_req` = `mem_we` = 0; `mem_addr` = `mem_wdata` = 0.
  - `i_ready` = `d_ready` = `err` = 0; `i_rdata` = `d_rdata` = 0.
  - Reset takes effect immediately (asynchronously), including mid-BUSY. The aborted transaction produces no ready pulse.
- **Latency:**
  - req sampled in IDLE at cycle 0.
  - `mem_req`=1 from cycle 1.
  - If ack arrives in cycle k ≥ 1, ready pulses in cycle k+1, and the FSM is back in IDLE at cycle k+2.
- **Throughput:** minimum 3 cycles per transaction (ack in the first BUSY cycle).
- **Simultaneous events:**
  - `i_req` and `d_req` both asserted in IDLE: resolved by the arbitration rule.
  - Ack in the same cycle as the timeout threshold: the ack wins, and `err`=0.
- **Timeout:** with no ack, ready and `err` pulse in cycle `TIMEOUT`+1 after the grant.

## Test plan
- I read at 0x100, memory acks 2 cycles after `mem_req` with 0xDEADBEEF → `mem_addr`=0x100, `mem_we`=0; `i_ready` pulses once with `i_rdata`=0xDEADBEEF; `d_ready` stays 0.
- D write of 0x12345678 to 0x200, ack in the first BUSY cycle → `mem_we`=1, `mem_wdata`=0x12345678; `d_ready` pulses 2 cycles after the grant; `d_rdata`=0.
- `i_req` and `d_req` raised in the same cycle → D served first, then I; exactly two grants; I's ready follows D's.
- `i_req` held high while D issues 6 back-to-back requests, `MAX_D_STREAK`=4 → grant order D, D, D, D, I, D, D.
- D read with `mem_ack` never asserted, `TIMEOUT`=8 → `mem_req` high for 8 cycles; `d_ready`=`err`=1 for one cycle; `d_rdata`=0; next request is served normally.
- `reset` driven low mid-BUSY → `mem_req` falls without waiting for the clock edge; no ready pulse; after release, a fresh I request completes normally.
